// File: rtl/compute_plain_broadcast_seq.sv
// Plain-broadcast sequencer: drives shared evaluator, multiplier and T-lane adder
// to build alpha = a + sum(eps*Q_d(r)) and beta = b + sum(S_d(r)) over active splits.
module compute_plain_broadcast_seq #(
  parameter int T       = 3,
  parameter int D_SPLIT = 2,
  parameter int SPLIT_W = $clog2(D_SPLIT + 1),
  parameter int DSEL_W  = (D_SPLIT > 1) ? $clog2(D_SPLIT) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [SPLIT_W-1:0]        i_n_split,
  input  logic [32*T-1:0]           i_r,
  input  logic [32*T*D_SPLIT-1:0]   i_eps,
  input  logic [32*T-1:0]           i_a,
  input  logic [32*T-1:0]           i_b,
  output logic                      o_eval_start,
  output logic                      o_eval_sel,
  output logic [DSEL_W-1:0]         o_eval_split,
  output logic [32*T-1:0]           o_eval_r,
  input  logic [32*T-1:0]           i_eval_out,
  input  logic                      i_eval_done,
  output logic                      o_mul_start,
  output logic [31:0]               o_mul_x,
  output logic [31:0]               o_mul_y,
  input  logic [31:0]               i_mul_o,
  input  logic                      i_mul_done,
  output logic                      o_add_start,
  output logic [32*T-1:0]           o_add_in_1,
  output logic [32*T-1:0]           o_add_in_2,
  input  logic [32*T-1:0]           i_add_out,
  input  logic                      i_add_done,
  output logic [32*T-1:0]           o_alpha,
  output logic [32*T-1:0]           o_beta,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int JW = (T > 1) ? $clog2(T) : 1;

  typedef logic [T-1:0][31:0] lanes_t;

  typedef enum logic [3:0] {
    IDLE, EVAL_Q, WAIT_Q, MUL, WAIT_MUL, ADD_A, WAIT_ADD_A,
    EVAL_S, WAIT_S, ADD_B, WAIT_ADD_B, NEXT, FIN
  } state_t;

  state_t                        state;
  logic [SPLIT_W-1:0]            n_q;
  logic [DSEL_W-1:0]             d_q;
  logic [JW-1:0]                 j_q;
  logic [D_SPLIT-1:0][T-1:0][31:0] eps_q;
  lanes_t                        qv_q, prod_q, alpha_acc, beta_acc;

  lanes_t             ev_lanes, add_lanes, eps_cur, prod_fwd;
  logic [SPLIT_W-1:0] n_in;
  logic [DSEL_W-1:0]  d_nx;
  logic [JW-1:0]      j_nx;
  logic               last_split;

  assign ev_lanes   = i_eval_out;
  assign add_lanes  = i_add_out;
  assign eps_cur    = eps_q[d_q];
  assign n_in       = (i_n_split > SPLIT_W'(D_SPLIT)) ? SPLIT_W'(D_SPLIT) : i_n_split;
  assign d_nx       = d_q + DSEL_W'(1);
  assign j_nx       = j_q + JW'(1);
  assign last_split = (SPLIT_W'(d_q) + SPLIT_W'(1)) == n_q;

  // The last product bypasses prod_q so the adder can start in the same edge it lands.
  for (genvar g = 0; g < T; g++) begin : g_lane
    assign prod_fwd[g] = (j_q == JW'(g)) ? i_mul_o : prod_q[g];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      n_q          <= '0;
      d_q          <= '0;
      j_q          <= '0;
      eps_q        <= '0;
      qv_q         <= '0;
      prod_q       <= '0;
      alpha_acc    <= '0;
      beta_acc     <= '0;
      o_eval_start <= 1'b0;
      o_eval_sel   <= 1'b0;
      o_eval_split <= '0;
      o_eval_r     <= '0;
      o_mul_start  <= 1'b0;
      o_mul_x      <= '0;
      o_mul_y      <= '0;
      o_add_start  <= 1'b0;
      o_add_in_1   <= '0;
      o_add_in_2   <= '0;
      o_alpha      <= '0;
      o_beta       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_eval_start <= 1'b0;
      o_mul_start  <= 1'b0;
      o_add_start  <= 1'b0;
      o_done       <= 1'b0;
      // Start pulses are raised on entry to their state; operands stay put until the next issue.
      case (state)
        IDLE: if (i_start) begin
          n_q       <= n_in;
          eps_q     <= i_eps;
          o_eval_r  <= i_r;
          alpha_acc <= i_a;
          beta_acc  <= i_b;
          d_q       <= '0;
          o_busy    <= 1'b1;
          if (n_in == '0) state <= FIN;
          else begin
            o_eval_start <= 1'b1;
            o_eval_sel   <= 1'b0;
            o_eval_split <= '0;
            state        <= EVAL_Q;
          end
        end
        EVAL_Q: state <= WAIT_Q;
        WAIT_Q: if (i_eval_done) begin
          qv_q        <= ev_lanes;
          j_q         <= '0;
          o_mul_x     <= eps_cur[0];
          o_mul_y     <= ev_lanes[0];
          o_mul_start <= 1'b1;
          state       <= MUL;
        end
        MUL: state <= WAIT_MUL;
        WAIT_MUL: if (i_mul_done) begin
          prod_q <= prod_fwd;
          if (j_q == JW'(T-1)) begin
            o_add_in_1  <= alpha_acc;
            o_add_in_2  <= prod_fwd;
            o_add_start <= 1'b1;
            state       <= ADD_A;
          end else begin
            j_q         <= j_nx;
            o_mul_x     <= eps_cur[j_nx];
            o_mul_y     <= qv_q[j_nx];
            o_mul_start <= 1'b1;
            state       <= MUL;
          end
        end
        ADD_A: state <= WAIT_ADD_A;
        WAIT_ADD_A: if (i_add_done) begin
          alpha_acc    <= add_lanes;
          o_eval_sel   <= 1'b1;
          o_eval_start <= 1'b1;
          state        <= EVAL_S;
        end
        EVAL_S: state <= WAIT_S;
        WAIT_S: if (i_eval_done) begin
          o_add_in_1  <= beta_acc;
          o_add_in_2  <= i_eval_out;
          o_add_start <= 1'b1;
          state       <= ADD_B;
        end
        ADD_B: state <= WAIT_ADD_B;
        WAIT_ADD_B: if (i_add_done) begin
          beta_acc <= add_lanes;
          state    <= NEXT;
        end
        NEXT: if (last_split) state <= FIN;
        else begin
          d_q          <= d_nx;
          o_eval_split <= d_nx;
          o_eval_sel   <= 1'b0;
          o_eval_start <= 1'b1;
          state        <= EVAL_Q;
        end
        FIN: begin
          o_alpha <= alpha_acc;
          o_beta  <= beta_acc;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
